cache_arbiter: RTL and testbench

- Shares the single physical-memory line port between the icache and dcache miss/writeback paths of the pipelined RV32I core.
- Sits between the two caches and the cacheline adaptor.
- Grants one requester at a time and holds the grant until the memory transaction completes.
- Alternates grants round-robin under contention, and keeps saturating wait-cycle counters for performance debug.

---
 rtl/cache_arbiter_pkg.sv | 28 ++
 rtl/cache_arbiter_sat_counter.sv | 46 ++++
 rtl/cache_arbiter.sv | 153 +++++++++++++++
 tb/tb_cache_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types and helpers for the cache arbiter
//
// Purpose : state and requester encodings used by cache_arbiter, plus the
//           line-alignment helper applied to both cache addresses.
// Ports   : none (package).

package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  // Clears the low off_w bits so the adaptor always sees a line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned off_w);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_arbiter_sat_counter.sv
// rtl/cache_arbiter_sat_counter.sv - saturating up-counter for wait statistics
//
// Purpose : counts cycles where inc_i is high, sticking at all-ones instead
//           of wrapping so a long stall never reads back as a short one.
// Ports   : clk    in   clock
//           rst    in   asynchronous active-high reset (clears count)
//           inc_i  in   count this cycle
//           clr_i  in   synchronous clear, wins over inc_i
//           cnt_o  out  current count (CNT_W bits)

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter for the shared physical-memory line port
//
// Purpose : lets the icache and dcache share one cacheline adaptor. One
//           requester is granted at a time and keeps the grant until the
//           adaptor answers with mem_resp; under contention the grant
//           alternates. Two saturating counters record how long each cache
//           waited while it was not being served.
// Ports   : clk, rst                        clock, async active-high reset
//           icache_pmem_read/address        icache line read request
//           icache_pmem_rdata/resp          line data and done to icache
//           dcache_pmem_read/write/address  dcache read / writeback request
//           dcache_pmem_wdata               dcache writeback line
//           dcache_pmem_rdata/resp          line data and done to dcache
//           mem_read/write/address/wdata    request to the adaptor
//           mem_rdata/resp                  adaptor data and done
//           icache_wait_cnt/dcache_wait_cnt cycles each cache waited ungranted

module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_pmem_read,
  input  logic [31:0]       icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,

  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [31:0]       dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,

  output logic [CNT_W-1:0]  icache_wait_cnt,
  output logic [CNT_W-1:0]  dcache_wait_cnt
);

  arb_state_t state_q, state_d;
  requester_t last_q, last_d;

  logic i_req;
  logic d_req;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Every mem_* output is a function of state_q, so a request can never
  // reach the adaptor in the cycle it first appears.
  always_comb begin
    state_d           = state_q;
    last_d            = last_q;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_address       = 32'h0;
    mem_wdata         = '0;
    icache_pmem_resp  = 1'b0;
    icache_pmem_rdata = '0;
    dcache_pmem_resp  = 1'b0;
    dcache_pmem_rdata = '0;

    unique case (state_q)
      IDLE: begin
        // mem_resp is deliberately ignored here: nobody owns the port.
        if (i_req && d_req) begin
          state_d = (last_q == REQ_I) ? SERVE_D : SERVE_I;
        end else if (i_req) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end

      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = line_align(icache_pmem_address, OFFSET_W);
        if (mem_resp) begin
          icache_pmem_resp  = 1'b1;
          icache_pmem_rdata = mem_rdata;
          last_d            = REQ_I;
          // Never straight back to SERVE_I: a back-to-back icache request
          // goes through IDLE so a waiting dcache wins the next grant.
          state_d           = d_req ? SERVE_D : IDLE;
        end
      end

      SERVE_D: begin
        // A writeback outranks a read when both are raised together.
        mem_write   = dcache_pmem_write;
        mem_read    = dcache_pmem_read & ~dcache_pmem_write;
        mem_address = line_align(dcache_pmem_address, OFFSET_W);
        mem_wdata   = dcache_pmem_wdata;
        if (mem_resp) begin
          dcache_pmem_resp  = 1'b1;
          dcache_pmem_rdata = mem_rdata;
          last_d            = REQ_D;
          state_d           = i_req ? SERVE_I : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_icache_wait (
    .clk   (clk),
    .rst   (rst),
    .inc_i (i_req && (state_q != SERVE_I)),
    .clr_i (1'b0),
    .cnt_o (icache_wait_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dcache_wait (
    .clk   (clk),
    .rst   (rst),
    .inc_i (d_req && (state_q != SERVE_D)),
    .clr_i (1'b0),
    .cnt_o (dcache_wait_cnt)
  );

  // A granted cache must hold its request until it sees its resp; dropping
  // it early leaves the adaptor mid-transfer with nobody listening.
  a_icache_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_I) |-> icache_pmem_read);

  a_dcache_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_D) |-> (dcache_pmem_read || dcache_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter

module tb_cache_arbiter;

  localparam int LW      = 256;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_pmem_read;
  logic [31:0]   icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [31:0]   dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic [CW-1:0] icache_wait_cnt;
  logic [CW-1:0] dcache_wait_cnt;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .OFFSET_W(5), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_address         (mem_address),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_resp            (mem_resp),
    .icache_wait_cnt     (icache_wait_cnt),
    .dcache_wait_cnt     (dcache_wait_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port (0 none, 1 icache, 2 dcache), who
  // was served last (1 icache, 2 dcache) and the two wait counts.
  int m_owner = 0;
  int m_last  = 1;
  int m_icnt  = 0;
  int m_dcnt  = 0;

  // DUT outputs as seen at the last negedge.
  logic          s_rd, s_wr, s_ir, s_dr;
  logic [31:0]   s_addr;
  logic [LW-1:0] s_wd, s_ird, s_drd;
  int            s_icnt, s_dcnt;

  int a_busy = 0;
  int a_lat  = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1;
    m_icnt  = 0;
    m_dcnt  = 0;
  endtask

  // Compare at the negedge, advance the model across the next posedge, and
  // return 1ns after it so the caller can drive the next cycle's inputs.
  task automatic cycle();
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [31:0]   e_addr;
    logic [LW-1:0] e_wd, e_ird, e_drd;
    int            n_owner, n_last, n_icnt, n_dcnt;
    bit            iw, dw;
    @(negedge clk);
    s_rd = mem_read;  s_wr = mem_write; s_addr = mem_address; s_wd = mem_wdata;
    s_ir = icache_pmem_resp; s_ird = icache_pmem_rdata;
    s_dr = dcache_pmem_resp; s_drd = dcache_pmem_rdata;
    s_icnt = int'(icache_wait_cnt); s_dcnt = int'(dcache_wait_cnt);

    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    e_addr = 32'h0; e_wd = '0; e_ird = '0; e_drd = '0;
    if (m_owner == 1) begin
      e_rd   = 1'b1;
      e_addr = icache_pmem_address & 32'hFFFF_FFE0;
      e_ir   = mem_resp;
      e_ird  = mem_resp ? mem_rdata : '0;
    end else if (m_owner == 2) begin
      e_wr   = dcache_pmem_write;
      e_rd   = dcache_pmem_read && !dcache_pmem_write;
      e_addr = dcache_pmem_address & 32'hFFFF_FFE0;
      e_wd   = dcache_pmem_wdata;
      e_dr   = mem_resp;
      e_drd  = mem_resp ? mem_rdata : '0;
    end
    chk("mem_read", s_rd, e_rd);
    chk("mem_write", s_wr, e_wr);
    chk("mem_address", s_addr, e_addr);
    chk("mem_wdata", s_wd, e_wd);
    chk("icache_resp", s_ir, e_ir);
    chk("icache_rdata", s_ird, e_ird);
    chk("dcache_resp", s_dr, e_dr);
    chk("dcache_rdata", s_drd, e_drd);
    chk("icache_wait_cnt", s_icnt, m_icnt);
    chk("dcache_wait_cnt", s_dcnt, m_dcnt);

    iw = icache_pmem_read;
    dw = dcache_pmem_read || dcache_pmem_write;
    n_owner = m_owner; n_last = m_last; n_icnt = m_icnt; n_dcnt = m_dcnt;
    if (iw && m_owner != 1 && m_icnt < CNT_MAX) n_icnt = m_icnt + 1;
    if (dw && m_owner != 2 && m_dcnt < CNT_MAX) n_dcnt = m_dcnt + 1;
    if (m_owner == 0) begin
      if (iw && dw)  n_owner = (m_last == 1) ? 2 : 1;
      else if (iw)   n_owner = 1;
      else if (dw)   n_owner = 2;
    end else if (mem_resp) begin
      n_last  = m_owner;
      n_owner = (m_owner == 1) ? (dw ? 2 : 0) : (iw ? 1 : 0);
    end
    if (rst) begin
      n_owner = 0; n_last = 1; n_icnt = 0; n_dcnt = 0;
    end
    @(posedge clk);
    m_owner = n_owner; m_last = n_last; m_icnt = n_icnt; m_dcnt = n_dcnt;
    #1;
  endtask

  task automatic clear_inputs();
    icache_pmem_read = 1'b0; icache_pmem_address = 32'h0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = 32'h0; dcache_pmem_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    clear_inputs();
    cycle();
    rst = 1'b0;
  endtask

  task automatic new_d();
    int k;
    k = $urandom_range(0, 2);
    dcache_pmem_read    = (k != 1);
    dcache_pmem_write   = (k != 0);
    dcache_pmem_address = $urandom;
    dcache_pmem_wdata   = rand_line();
  endtask

  task automatic agents(input bit allow_new);
    if (s_ir) begin
      if (allow_new && $urandom_range(0, 1) == 1) icache_pmem_address = $urandom;
      else icache_pmem_read = 1'b0;
    end else if (allow_new && !icache_pmem_read && $urandom_range(0, 2) == 0) begin
      icache_pmem_read    = 1'b1;
      icache_pmem_address = $urandom;
    end
    if (s_dr) begin
      if (allow_new && $urandom_range(0, 1) == 1) new_d();
      else begin dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0; end
    end else if (allow_new && !(dcache_pmem_read || dcache_pmem_write) &&
                 $urandom_range(0, 2) == 0) begin
      new_d();
    end
  endtask

  // Adaptor: random latency per transaction, plus occasional stray resp
  // pulses while the port is idle.
  task automatic adaptor();
    if (mem_resp) begin
      mem_resp = 1'b0;
      a_busy   = 0;
    end
    if (mem_read || mem_write) begin
      if (a_busy == 0) begin
        a_busy = 1;
        a_lat  = $urandom_range(0, 4);
      end
      if (a_lat == 0) begin
        mem_resp  = 1'b1;
        mem_rdata = rand_line();
      end else begin
        a_lat--;
      end
    end else if ($urandom_range(0, 5) == 0) begin
      mem_resp  = 1'b1;
      mem_rdata = rand_line();
    end
  endtask

  initial begin
    int n;
    int who;
    logic [LW-1:0] aa_line;
    logic [LW-1:0] wd_line;

    // Reset with every input active: nothing may leak through.
    rst = 1'b1;
    model_reset();
    clear_inputs();
    icache_pmem_read = 1'b1; dcache_pmem_write = 1'b1; mem_resp = 1'b1;
    mem_rdata = {LW{1'b1}};
    cycle();
    cycle();
    chk("rst_mem_read", s_rd, 0);
    chk("rst_mem_write", s_wr, 0);
    chk("rst_icache_resp", s_ir, 0);
    chk("rst_icache_cnt", s_icnt, 0);
    do_reset();

    // Lone icache read.
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_0064;
    cycle();
    chk("lone_i_idle_read", s_rd, 0);
    cycle();
    chk("lone_i_read", s_rd, 1);
    chk("lone_i_addr", s_addr, 32'h0000_0060);
    repeat (9) cycle();
    aa_line = {(LW / 8){8'hAA}};
    mem_resp = 1'b1; mem_rdata = aa_line;
    cycle();
    chk("lone_i_resp", s_ir, 1);
    chk("lone_i_rdata", s_ird, aa_line);
    mem_resp = 1'b0; icache_pmem_read = 1'b0;
    cycle();
    chk("lone_i_idle_after", s_rd, 0);

    // Simultaneous requests out of reset: dcache first, then icache directly.
    do_reset();
    wd_line = {(LW / 32){32'hDEAD_BEEF}};
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_1234;
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h0000_8888;
    dcache_pmem_wdata = wd_line;
    cycle();
    chk("both_idle_cnt", s_icnt, 0);
    cycle();
    chk("both_d_write", s_wr, 1);
    chk("both_d_read", s_rd, 0);
    chk("both_d_wdata", s_wd, wd_line);
    chk("both_d_addr", s_addr, 32'h0000_8880);
    chk("both_icnt1", s_icnt, 1);
    cycle();
    mem_resp = 1'b1; mem_rdata = rand_line();
    cycle();
    chk("both_d_resp", s_dr, 1);
    chk("both_icnt3", s_icnt, 3);
    mem_resp = 1'b0; dcache_pmem_write = 1'b0;
    cycle();
    chk("both_i_nobubble", s_rd, 1);
    chk("both_i_addr", s_addr, 32'h0000_1220);
    chk("both_icnt4", s_icnt, 4);
    mem_resp = 1'b1; mem_rdata = rand_line();
    cycle();
    mem_resp = 1'b0; icache_pmem_read = 1'b0;
    cycle();

    // Continuous contention: D,I,D,I,D,I.
    do_reset();
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_0100;
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h0000_0200;
    dcache_pmem_wdata = rand_line();
    for (int t = 0; t < 6; t++) begin
      n = 0;
      do begin
        cycle();
        n++;
      end while (!(s_rd || s_wr) && n < 4);
      chk("rr_grant_seen", s_rd || s_wr, 1);
      who = s_wr ? 2 : 1;
      chk("rr_order", who, (t % 2 == 0) ? 2 : 1);
      if (t > 0) chk("rr_no_bubble", n, 1);
      mem_resp = 1'b1; mem_rdata = rand_line();
      cycle();
      mem_resp = 1'b0;
    end
    icache_pmem_read = 1'b0;
    cycle();
    mem_resp = 1'b1;
    cycle();
    mem_resp = 1'b0; dcache_pmem_write = 1'b0;
    cycle();

    // Read and write together: write wins.
    do_reset();
    dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1;
    dcache_pmem_address = 32'h0000_0040; dcache_pmem_wdata = rand_line();
    cycle();
    cycle();
    chk("rw_write", s_wr, 1);
    chk("rw_read", s_rd, 0);
    mem_resp = 1'b1; mem_rdata = rand_line();
    cycle();
    chk("rw_resp", s_dr, 1);
    mem_resp = 1'b0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a dcache writeback.
    do_reset();
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_0300;
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h0000_0400;
    dcache_pmem_wdata = rand_line();
    cycle();
    cycle();
    cycle();
    chk("arst_pre_write", s_wr, 1);
    chk("arst_pre_icnt", s_icnt, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_write_drop", mem_write, 0);
    chk("arst_icnt_zero", icache_wait_cnt, 0);
    chk("arst_dcnt_zero", dcache_wait_cnt, 0);
    model_reset();
    dcache_pmem_write = 1'b0;
    rst = 1'b0;
    cycle();
    chk("arst_idle", s_rd, 0);
    cycle();
    chk("arst_i_grant", s_rd, 1);
    chk("arst_i_addr", s_addr, 32'h0000_0300);
    mem_resp = 1'b1; mem_rdata = rand_line();
    cycle();
    mem_resp = 1'b0; icache_pmem_read = 1'b0;
    cycle();

    // icache starved behind a long dcache transfer: counter sticks at max.
    do_reset();
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_0500;
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h0000_0600;
    dcache_pmem_wdata = rand_line();
    repeat (22) cycle();
    chk("sat_still_d", s_wr, 1);
    chk("sat_icnt", s_icnt, 15);
    mem_resp = 1'b1; mem_rdata = rand_line();
    cycle();
    mem_resp = 1'b0; dcache_pmem_write = 1'b0;
    cycle();
    chk("sat_i_grant", s_rd, 1);
    chk("sat_icnt_hold", s_icnt, 15);
    mem_resp = 1'b1; mem_rdata = rand_line();
    cycle();
    mem_resp = 1'b0; icache_pmem_read = 1'b0;
    cycle();

    // Randomized traffic against the model.
    do_reset();
    a_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      agents(1'b1);
      #1;
      adaptor();
    end
    n = 0;
    while ((icache_pmem_read || dcache_pmem_read || dcache_pmem_write) && n < 200) begin
      cycle();
      agents(1'b0);
      #1;
      adaptor();
      n++;
    end
    chk("drain_done", icache_pmem_read || dcache_pmem_read || dcache_pmem_write, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
